// File: rtl/player_datapath_if.sv
// player_datapath_if
// Groups the command and plot signals exchanged between the player control
// FSM (master) and the player datapath (slave).
//   calc_op/calc_go : position operation and its apply strobe
//   load_p          : commit pending position to current position
//   draw            : start an erase+redraw sequence
//   pos_x/pos_y     : current committed position
//   vga_x/vga_y     : plot coordinates for the VGA adapter
//   colour/plot     : plot colour and pixel write strobe
//   busy            : draw engine active
interface player_datapath_if;
    logic [3:0] calc_op;
    logic       calc_go;
    logic       load_p;
    logic       draw;
    logic [7:0] pos_x;
    logic [6:0] pos_y;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;

    modport master (
        output calc_op, calc_go, load_p, draw,
        input  pos_x, pos_y, vga_x, vga_y, colour, plot, busy
    );

    modport slave (
        input  calc_op, calc_go, load_p, draw,
        output pos_x, pos_y, vga_x, vga_y, colour, plot, busy
    );
endinterface

// File: rtl/player_datapath.sv
// player_datapath
// Datapath partner of the player control FSM. Position commands accumulate
// on a pending register and are committed on load_p. A draw pulse runs a
// pixel engine that erases the sprite where it was last drawn, then paints it
// at the committed position, one pixel per cycle.
// Ports:
//   clock  : single clock, posedge
//   resetn : synchronous active-low reset
//   bus    : player_datapath_if.slave (commands in, position/plot out)
module player_datapath #(
    parameter int         X_INIT    = 8,
    parameter int         GROUND_Y  = 100,
    parameter int         Y_MIN     = 0,
    parameter int         SCREEN_W  = 160,
    parameter int         SPRITE_W  = 4,
    parameter int         SPRITE_H  = 4,
    parameter int         STEP      = 1,
    parameter int         JUMP_HI   = 8,
    parameter int         JUMP_LO   = 4,
    parameter logic [2:0] BG_COLOUR = 3'b000,
    parameter logic [2:0] P_COLOUR  = 3'b111
) (
    input  logic              clock,
    input  logic              resetn,
    player_datapath_if.slave  bus
);

    localparam int PIXELS = SPRITE_W * SPRITE_H;
    localparam int CNT_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXELS - 1);

    // 9-bit signed limits so that a step below zero shows up as negative
    localparam logic signed [8:0] X_MAX_S  = 9'(SCREEN_W - SPRITE_W);
    localparam logic signed [8:0] STEP_S   = 9'(STEP);
    localparam logic signed [8:0] HI_S     = 9'(JUMP_HI);
    localparam logic signed [8:0] LO_S     = 9'(JUMP_LO);
    localparam logic signed [8:0] YMIN_S   = 9'(Y_MIN);
    localparam logic signed [8:0] GROUND_S = 9'(GROUND_Y);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ERASE = 2'd1;
    localparam logic [1:0] S_PAINT = 2'd2;

    logic [7:0] nx, pos_x, last_x, erase_x, draw_x;
    logic [6:0] ny, pos_y, last_y, erase_y, draw_y;
    logic [7:0] nx_next;
    logic [6:0] ny_next;
    logic signed [8:0] x_wide, y_wide;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [7:0]       vga_x;
    logic [6:0]       vga_y;
    logic [2:0]       colour;
    logic             plot;

    // Row-major pixel offsets within the sprite
    function automatic logic [7:0] off_x(input logic [CNT_W-1:0] idx);
        return 8'(int'(idx) % SPRITE_W);
    endfunction

    function automatic logic [6:0] off_y(input logic [CNT_W-1:0] idx);
        return 7'(int'(idx) / SPRITE_W);
    endfunction

    // Saturating position arithmetic for every calc_op code
    always_comb begin
        nx_next = nx;
        ny_next = ny;
        x_wide  = '0;
        y_wide  = '0;
        case (bus.calc_op)
            4'b0000: begin
                x_wide  = $signed({1'b0, nx}) + STEP_S;
                nx_next = (x_wide > X_MAX_S) ? 8'(SCREEN_W - SPRITE_W) : x_wide[7:0];
            end
            4'b0001: begin
                x_wide  = $signed({1'b0, nx}) - STEP_S;
                nx_next = (x_wide < 9'sd0) ? 8'd0 : x_wide[7:0];
            end
            4'b0101: begin
                y_wide  = $signed({2'b00, ny}) - HI_S;
                ny_next = (y_wide < YMIN_S) ? 7'(Y_MIN) : y_wide[6:0];
            end
            4'b0011: begin
                y_wide  = $signed({2'b00, ny}) - LO_S;
                ny_next = (y_wide < YMIN_S) ? 7'(Y_MIN) : y_wide[6:0];
            end
            4'b0010: begin
                y_wide  = $signed({2'b00, ny}) + LO_S;
                ny_next = (y_wide > GROUND_S) ? 7'(GROUND_Y) : y_wide[6:0];
            end
            4'b0100: begin
                y_wide  = $signed({2'b00, ny}) + HI_S;
                ny_next = (y_wide > GROUND_S) ? 7'(GROUND_Y) : y_wide[6:0];
            end
            default: ;
        endcase
    end

    // Pending and committed position; a same-cycle load commits the old pending value
    always_ff @(posedge clock) begin
        if (!resetn) begin
            nx    <= 8'(X_INIT);
            ny    <= 7'(GROUND_Y);
            pos_x <= 8'(X_INIT);
            pos_y <= 7'(GROUND_Y);
        end else begin
            if (bus.calc_go) begin
                nx <= nx_next;
                ny <= ny_next;
            end
            if (bus.load_p) begin
                pos_x <= nx;
                pos_y <= ny;
            end
        end
    end

    assign cnt_inc = cnt + CNT_W'(1);

    // Draw engine: cnt indexes the pixel currently on the plot outputs, so
    // each edge emits the pixel after it, or moves to the next phase.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            last_x  <= 8'(X_INIT);
            last_y  <= 7'(GROUND_Y);
            erase_x <= '0;
            erase_y <= '0;
            draw_x  <= '0;
            draw_y  <= '0;
            vga_x   <= '0;
            vga_y   <= '0;
            colour  <= BG_COLOUR;
            plot    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.draw) begin
                        erase_x <= last_x;
                        erase_y <= last_y;
                        draw_x  <= pos_x;
                        draw_y  <= pos_y;
                        last_x  <= pos_x;
                        last_y  <= pos_y;
                        cnt     <= '0;
                        vga_x   <= last_x + off_x('0);
                        vga_y   <= last_y + off_y('0);
                        colour  <= BG_COLOUR;
                        plot    <= 1'b1;
                        state   <= S_ERASE;
                    end
                end
                S_ERASE: begin
                    if (cnt == LAST_CNT) begin
                        cnt    <= '0;
                        vga_x  <= draw_x + off_x('0);
                        vga_y  <= draw_y + off_y('0);
                        colour <= P_COLOUR;
                        state  <= S_PAINT;
                    end else begin
                        cnt   <= cnt_inc;
                        vga_x <= erase_x + off_x(cnt_inc);
                        vga_y <= erase_y + off_y(cnt_inc);
                    end
                end
                S_PAINT: begin
                    if (cnt == LAST_CNT) begin
                        cnt   <= '0;
                        plot  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        cnt   <= cnt_inc;
                        vga_x <= draw_x + off_x(cnt_inc);
                        vga_y <= draw_y + off_y(cnt_inc);
                    end
                end
                default: begin
                    plot  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pos_x  = pos_x;
    assign bus.pos_y  = pos_y;
    assign bus.vga_x  = vga_x;
    assign bus.vga_y  = vga_y;
    assign bus.colour = colour;
    assign bus.plot   = plot;
    assign bus.busy   = (state != S_IDLE);

endmodule

// File: tb/tb_player_datapath.sv
// tb_player_datapath
// Drives player_datapath through directed scenarios and random commands and
// compares every cycle against a pixel-list reference model.
module tb_player_datapath;

    localparam int X_INIT   = 8;
    localparam int GROUND_Y = 100;
    localparam int Y_MIN    = 0;
    localparam int X_MAX    = 156;
    localparam int SPR_W    = 4;
    localparam int SPR_H    = 4;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    always #5 clock = ~clock;

    player_datapath_if bus();

    player_datapath dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
    } pixel_t;

    // Pixels still to appear on the plot port, in order
    pixel_t expQ[$];

    int m_nx, m_ny, m_px, m_py, m_dx, m_dy;
    int m_plot, m_vx, m_vy, m_col;
    int total = 0;
    int bad = 0;
    int plotCount = 0;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference behaviour at one rising edge
    task automatic modelEdge(input logic [3:0] op, input logic go, input logic ld,
                             input logic dr, input logic rn);
        int nnx, nny;
        pixel_t p;
        if (!rn) begin
            m_nx = X_INIT;  m_ny = GROUND_Y;
            m_px = X_INIT;  m_py = GROUND_Y;
            m_dx = X_INIT;  m_dy = GROUND_Y;
            expQ.delete();
            m_plot = 0; m_vx = 0; m_vy = 0; m_col = 0;
        end else begin
            nnx = m_nx;
            nny = m_ny;
            if (go) begin
                case (op)
                    4'b0000: nnx = imin(m_nx + 1, X_MAX);
                    4'b0001: nnx = imax(m_nx - 1, 0);
                    4'b0101: nny = imax(m_ny - 8, Y_MIN);
                    4'b0011: nny = imax(m_ny - 4, Y_MIN);
                    4'b0010: nny = imin(m_ny + 4, GROUND_Y);
                    4'b0100: nny = imin(m_ny + 8, GROUND_Y);
                    default: ;
                endcase
            end
            if (dr && m_plot == 0) begin
                for (int i = 0; i < SPR_W * SPR_H; i++)
                    expQ.push_back('{x: m_dx + i % SPR_W, y: m_dy + i / SPR_W, c: 0});
                for (int i = 0; i < SPR_W * SPR_H; i++)
                    expQ.push_back('{x: m_px + i % SPR_W, y: m_py + i / SPR_W, c: 7});
                m_dx = m_px;
                m_dy = m_py;
            end
            if (ld) begin
                m_px = m_nx;
                m_py = m_ny;
            end
            m_nx = nnx;
            m_ny = nny;
            if (expQ.size() > 0) begin
                p = expQ.pop_front();
                m_plot = 1; m_vx = p.x; m_vy = p.y; m_col = p.c;
            end else begin
                m_plot = 0;
            end
        end
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge
    task automatic applyStimulus(input logic [3:0] op, input logic go, input logic ld,
                                 input logic dr, input logic rn);
        bus.calc_op = op;
        bus.calc_go = go;
        bus.load_p  = ld;
        bus.draw    = dr;
        resetn      = rn;
        @(posedge clock);
        modelEdge(op, go, ld, dr, rn);
        @(negedge clock);
        checkOutput("pos_x",  int'(bus.pos_x),  m_px);
        checkOutput("pos_y",  int'(bus.pos_y),  m_py);
        checkOutput("plot",   int'(bus.plot),   m_plot);
        checkOutput("busy",   int'(bus.busy),   m_plot);
        checkOutput("vga_x",  int'(bus.vga_x),  m_vx);
        checkOutput("vga_y",  int'(bus.vga_y),  m_vy);
        checkOutput("colour", int'(bus.colour), m_col);
        if (bus.plot === 1'b1) plotCount++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic calcOp(input logic [3:0] op);
        applyStimulus(op, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic loadPos();
        applyStimulus(4'b0000, 1'b0, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic startDraw();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic doReset();
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.calc_op = 4'b0000;
        bus.calc_go = 1'b0;
        bus.load_p  = 1'b0;
        bus.draw    = 1'b0;

        // Reset state
        doReset();
        checkOutput("reset_pos_x", int'(bus.pos_x), 8);
        checkOutput("reset_pos_y", int'(bus.pos_y), 100);
        checkOutput("reset_plot",  int'(bus.plot),  0);
        checkOutput("reset_busy",  int'(bus.busy),  0);

        // First draw after reset: erase then paint the same 4x4 block
        startDraw();
        checkOutput("first_erase_x", int'(bus.vga_x),  8);
        checkOutput("first_erase_c", int'(bus.colour), 0);
        idleCycles(31);
        checkOutput("last_paint_x", int'(bus.vga_x),  11);
        checkOutput("last_paint_y", int'(bus.vga_y),  103);
        checkOutput("last_paint_c", int'(bus.colour), 7);
        idleCycles(1);
        checkOutput("draw_done_busy", int'(bus.busy), 0);

        // Move right by one and redraw
        calcOp(4'b0000);
        loadPos();
        checkOutput("move_pos_x", int'(bus.pos_x), 9);
        startDraw();
        checkOutput("move_erase_x", int'(bus.vga_x), 8);
        idleCycles(16);
        checkOutput("move_paint_x", int'(bus.vga_x),  9);
        checkOutput("move_paint_y", int'(bus.vga_y),  100);
        checkOutput("move_paint_c", int'(bus.colour), 7);
        idleCycles(16);
        checkOutput("move_done_busy", int'(bus.busy), 0);

        // Full jump to the left
        doReset();
        calcOp(4'b0101); calcOp(4'b0001); loadPos();
        checkOutput("jump1_y", int'(bus.pos_y), 92);
        checkOutput("jump1_x", int'(bus.pos_x), 7);
        calcOp(4'b0011); calcOp(4'b0001); loadPos();
        checkOutput("jump2_y", int'(bus.pos_y), 88);
        checkOutput("jump2_x", int'(bus.pos_x), 6);
        calcOp(4'b0010); calcOp(4'b0001); loadPos();
        checkOutput("jump3_y", int'(bus.pos_y), 92);
        checkOutput("jump3_x", int'(bus.pos_x), 5);
        calcOp(4'b0100); calcOp(4'b0001); loadPos();
        checkOutput("jump4_y", int'(bus.pos_y), 100);
        checkOutput("jump4_x", int'(bus.pos_x), 4);

        // Clamping at all four limits
        doReset();
        for (int i = 0; i < 147; i++) calcOp(4'b0000);
        loadPos();
        checkOutput("clamp_x155", int'(bus.pos_x), 155);
        calcOp(4'b0000); calcOp(4'b0000); loadPos();
        checkOutput("clamp_xmax", int'(bus.pos_x), 156);
        for (int i = 0; i < 160; i++) calcOp(4'b0001);
        calcOp(4'b0001);
        loadPos();
        checkOutput("clamp_x0", int'(bus.pos_x), 0);
        for (int i = 0; i < 12; i++) calcOp(4'b0101);
        loadPos();
        checkOutput("clamp_y4", int'(bus.pos_y), 4);
        calcOp(4'b0101); loadPos();
        checkOutput("clamp_ymin", int'(bus.pos_y), 0);
        for (int i = 0; i < 14; i++) calcOp(4'b0100);
        loadPos();
        checkOutput("clamp_ground", int'(bus.pos_y), 100);
        calcOp(4'b1111); loadPos();
        checkOutput("invalid_op_y", int'(bus.pos_y), 100);

        // Draw while busy is ignored
        doReset();
        plotCount = 0;
        startDraw();
        idleCycles(4);
        startDraw();
        idleCycles(40);
        checkOutput("plot_count", plotCount, 32);

        // load_p mid-frame does not move the in-flight paint
        calcOp(4'b0000);
        startDraw();
        idleCycles(2);
        loadPos();
        idleCycles(13);
        checkOutput("latched_paint_x", int'(bus.vga_x),  8);
        checkOutput("latched_paint_c", int'(bus.colour), 7);
        checkOutput("latched_pos_x",   int'(bus.pos_x),  9);
        idleCycles(16);

        // Reset in the middle of a frame
        startDraw();
        idleCycles(9);
        applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("midreset_plot", int'(bus.plot), 0);
        checkOutput("midreset_busy", int'(bus.busy), 0);
        idleCycles(1);
        startDraw();
        checkOutput("post_reset_erase_x", int'(bus.vga_x),  8);
        checkOutput("post_reset_erase_y", int'(bus.vga_y),  100);
        checkOutput("post_reset_erase_c", int'(bus.colour), 0);
        idleCycles(32);

        // Random command mix
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(4'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 149) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
